// File: rtl/proc_sim_pkg.sv
// Shared definitions for the processor run controller: default parameter
// values, the run-state encoding and a saturating counter helper.
package proc_sim_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_RST_CYCLES  = 2;
  localparam int unsigned DEF_MAX_CYCLES  = 1024;
  localparam int unsigned DEF_HALT_REPEAT = 4;
  localparam int unsigned DEF_TRACE_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace buffer for processor writebacks: a circular FIFO with a sticky
// overflow flag. The head entry is presented combinationally on rdata_o.
module trace_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  clr_ovf_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  // Depth must be a power of two (>= 2) so the pointers wrap for free.
  localparam int unsigned AW = $clog2(TRACE_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(TRACE_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [TRACE_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  ovf_q;

  logic do_pop;
  logic do_push;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign overflow_o = ovf_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push when it is popped at the same time.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head entry; forced to zero when empty so reset shows a clean value.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Entry storage.
  // NOTE: storage is not reset; the empty flag gates rdata_o so stale contents never show.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (clr_ovf_i) begin
        ovf_q <= 1'b0;
      end else if (push_i && !do_push) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/proc_run_controller.sv
// Run controller for a processor under test: holds the core in reset for a
// fixed number of cycles, lets it run, stops on halt (PC stuck) or timeout,
// and records writeback values in a trace FIFO.
module proc_run_controller
  import proc_sim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT,
  parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] PCInstruction,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  WriteValid,
  input  logic                  TraceRdEn,
  output logic                  CoreRst,
  output logic                  Running,
  output logic                  Done,
  output logic                  Halted,
  output logic                  TimedOut,
  output logic [31:0]           CycleCount,
  output logic [DATA_WIDTH-1:0] TraceData,
  output logic                  TraceEmpty,
  output logic                  TraceFull,
  output logic                  TraceOverflow
);

  run_state_e            state_q;
  logic [7:0]            hold_q;
  logic [31:0]           cycle_q;
  logic [DATA_WIDTH-1:0] pc_prev_q;
  logic                  prev_valid_q;
  logic [7:0]            rep_q;
  logic                  core_rst_q;
  logic                  running_q;
  logic                  done_q;
  logic                  halted_q;
  logic                  timedout_q;

  logic [31:0] cycle_inc;
  logic [7:0]  rep_d;
  logic        halt_hit;
  logic        timeout_hit;
  logic        accept_start;

  // Halt/timeout detection for the current RUN cycle. The first RUN cycle
  // has no previous PC of the run, so it never counts as a repeat.
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    cycle_inc = sat_inc32(cycle_q);
    rep_d     = '0;
    if (prev_valid_q && (PCInstruction == pc_prev_q)) begin
      rep_d = rep_q + 8'd1;
    end
    halt_hit     = (rep_d >= 8'(HALT_REPEAT));
    timeout_hit  = (cycle_inc >= 32'(MAX_CYCLES));
    accept_start = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  // Run-control FSM with registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      cycle_q      <= '0;
      pc_prev_q    <= '0;
      prev_valid_q <= 1'b0;
      rep_q        <= '0;
      core_rst_q   <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      halted_q     <= 1'b0;
      timedout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_start) begin
            state_q    <= ST_HOLD;
            hold_q     <= 8'(RST_CYCLES);
            cycle_q    <= '0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            timedout_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (hold_q <= 8'd1) begin
            state_q      <= ST_RUN;
            core_rst_q   <= 1'b0;
            running_q    <= 1'b1;
            prev_valid_q <= 1'b0;
            rep_q        <= '0;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        ST_RUN: begin
          cycle_q      <= cycle_inc;
          pc_prev_q    <= PCInstruction;
          prev_valid_q <= 1'b1;
          rep_q        <= rep_d;
          if (halt_hit || timeout_hit) begin
            state_q    <= ST_DONE;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b1;
            halted_q   <= halt_hit;
            timedout_q <= timeout_hit;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CoreRst    = core_rst_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign Halted     = halted_q;
  assign TimedOut   = timedout_q;
  assign CycleCount = cycle_q;

  trace_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_trace_fifo (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .push_i    ((state_q == ST_RUN) && WriteValid),
    .pop_i     (TraceRdEn),
    .clr_ovf_i (accept_start),
    .wdata_i   (WriteData),
    .rdata_o   (TraceData),
    .empty_o   (TraceEmpty),
    .full_o    (TraceFull),
    .overflow_o(TraceOverflow)
  );

endmodule

// File: tb/tb_proc_run_controller.sv
// Self-checking bench for proc_run_controller: directed run scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_proc_run_controller;

  localparam int DW    = 32;
  localparam int RSTC  = 2;
  localparam int MAXC  = 16;
  localparam int HREP  = 4;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic [DW-1:0] PCInstruction;
  logic [DW-1:0] WriteData;
  logic          WriteValid;
  logic          TraceRdEn;
  logic          CoreRst;
  logic          Running;
  logic          Done;
  logic          Halted;
  logic          TimedOut;
  logic [31:0]   CycleCount;
  logic [DW-1:0] TraceData;
  logic          TraceEmpty;
  logic          TraceFull;
  logic          TraceOverflow;

  always #5 Clk = ~Clk;

  proc_run_controller #(
    .DATA_WIDTH (DW),
    .RST_CYCLES (RSTC),
    .MAX_CYCLES (MAXC),
    .HALT_REPEAT(HREP),
    .TRACE_DEPTH(DEPTH)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Start        (Start),
    .PCInstruction(PCInstruction),
    .WriteData    (WriteData),
    .WriteValid   (WriteValid),
    .TraceRdEn    (TraceRdEn),
    .CoreRst      (CoreRst),
    .Running      (Running),
    .Done         (Done),
    .Halted       (Halted),
    .TimedOut     (TimedOut),
    .CycleCount   (CycleCount),
    .TraceData    (TraceData),
    .TraceEmpty   (TraceEmpty),
    .TraceFull    (TraceFull),
    .TraceOverflow(TraceOverflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the run's PC history is a queue (its length is the
  // cycle count), the trace is a queue of entries.
  typedef enum int {M_IDLE, M_HOLD, M_RUN, M_DONE} mphase_e;
  mphase_e       m_phase = M_IDLE;
  int            m_hold_left = 0;
  logic [31:0]   m_hist[$];
  logic [DW-1:0] m_fifo[$];
  bit            m_ovf = 1'b0;
  bit            m_halted = 1'b0;
  bit            m_timed = 1'b0;

  task automatic model_step();
    bit h;
    bit t;
    int last;
    if (Rst) begin
      m_phase  = M_IDLE;
      m_hist.delete();
      m_fifo.delete();
      m_ovf    = 1'b0;
      m_halted = 1'b0;
      m_timed  = 1'b0;
      return;
    end
    if (TraceRdEn && m_fifo.size() > 0) begin
      void'(m_fifo.pop_front());
    end
    if (m_phase == M_RUN && WriteValid) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(WriteData);
      else m_ovf = 1'b1;
    end
    case (m_phase)
      M_IDLE, M_DONE: begin
        if (Start) begin
          m_phase     = M_HOLD;
          m_hold_left = RSTC;
          m_hist.delete();
          m_halted    = 1'b0;
          m_timed     = 1'b0;
          m_ovf       = 1'b0;
        end
      end
      M_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) m_phase = M_RUN;
      end
      default: begin
        m_hist.push_back(PCInstruction);
        last = m_hist.size() - 1;
        h = (m_hist.size() >= HREP + 1);
        for (int k = 1; k <= HREP; k++) begin
          if (h && m_hist[last - k] != m_hist[last]) h = 1'b0;
        end
        t = (m_hist.size() >= MAXC);
        if (h || t) begin
          m_phase  = M_DONE;
          m_halted = h;
          m_timed  = t;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] head;
    head = (m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
    check("CoreRst",       32'(CoreRst),       32'(m_phase != M_RUN));
    check("Running",       32'(Running),       32'(m_phase == M_RUN));
    check("Done",          32'(Done),          32'(m_phase == M_DONE));
    check("Halted",        32'(Halted),        32'(m_halted));
    check("TimedOut",      32'(TimedOut),      32'(m_timed));
    check("CycleCount",    CycleCount,         32'(m_hist.size()));
    check("TraceData",     TraceData,          head);
    check("TraceEmpty",    32'(TraceEmpty),    32'(m_fifo.size() == 0));
    check("TraceFull",     32'(TraceFull),     32'(m_fifo.size() == DEPTH));
    check("TraceOverflow", 32'(TraceOverflow), 32'(m_ovf));
  endtask

  // One clock: advance the model with the driven inputs, then compare #1
  // after the edge.
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    bit was;
    logic [31:0] pc;
    logic [31:0] exp;

    Rst = 1'b1; Start = 1'b0; PCInstruction = '0; WriteData = '0;
    WriteValid = 1'b0; TraceRdEn = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    check("rst_corerst", 32'(CoreRst), 32'd1);
    check("rst_empty", 32'(TraceEmpty), 32'd1);
    check("rst_tracedata", TraceData, 32'd0);
    tick();

    // Hold length, then halt on a stuck PC.
    start_pulse();
    n = 0;
    while (CoreRst && n < 10) begin tick(); n++; end
    check("hold_cycles", 32'(n), 32'd2);
    check("run_entry", 32'(Running), 32'd1);
    pc = 32'h30;
    n = 0;
    while (!Done && n < 30) begin
      PCInstruction = pc;
      tick();
      n++;
      if (pc < 32'h40) pc += 4;
    end
    check("halt_flag", 32'(Halted), 32'd1);
    check("halt_no_timeout", 32'(TimedOut), 32'd0);
    check("halt_cycles", CycleCount, 32'd9);
    tick(); tick(); tick();
    check("halt_frozen", CycleCount, 32'd9);

    // Timeout while filling the trace with 1..16.
    pc = 32'h100;
    start_pulse();
    k = 1; n = 0;
    while (!Done && n < 40) begin
      was = Running;
      WriteValid = Running; WriteData = 32'(k); PCInstruction = pc;
      tick();
      if (was) k++;
      pc += 4; n++;
    end
    WriteValid = 1'b0;
    check("to_timedout", 32'(TimedOut), 32'd1);
    check("to_done", 32'(Done), 32'd1);
    check("to_cycles", CycleCount, 32'd16);
    check("to_full", 32'(TraceFull), 32'd1);

    // Four more writes (0x11..0x14) are dropped and flag overflow.
    start_pulse();
    k = 0; n = 0;
    while (!Done && n < 40) begin
      WriteValid = Running && k < 4; WriteData = 32'(17 + k); PCInstruction = pc;
      was = WriteValid;
      tick();
      if (was) k++;
      pc += 4; n++;
    end
    WriteValid = 1'b0;
    check("ovf_set", 32'(TraceOverflow), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      check("pop_seq", TraceData, 32'(i));
      TraceRdEn = 1'b1;
      tick();
    end
    TraceRdEn = 1'b0;
    check("pop_empty", 32'(TraceEmpty), 32'd1);

    // Refill with 0xA0.., then push+pop while full.
    start_pulse();
    k = 0; n = 0;
    while (!Done && n < 40) begin
      was = Running;
      WriteValid = Running; WriteData = 32'hA0 + 32'(k); PCInstruction = pc;
      tick();
      if (was) k++;
      pc += 4; n++;
    end
    WriteValid = 1'b0;
    check("refill_full", 32'(TraceFull), 32'd1);
    start_pulse();
    check("start_clears_ovf", 32'(TraceOverflow), 32'd0);
    k = 0; n = 0;
    while (!Done && n < 40) begin
      WriteValid = Running && k < 3; TraceRdEn = Running && k < 3;
      WriteData = 32'hB0 + 32'(k); PCInstruction = pc;
      was = WriteValid;
      tick();
      if (was) begin k++; check("pp_full", 32'(TraceFull), 32'd1); end
      pc += 4; n++;
    end
    WriteValid = 1'b0; TraceRdEn = 1'b0;
    check("pp_no_ovf", 32'(TraceOverflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp = (i < 13) ? 32'hA3 + 32'(i) : 32'hB0 + 32'(i - 13);
      check("pp_order", TraceData, exp);
      TraceRdEn = 1'b1;
      tick();
    end
    TraceRdEn = 1'b0;

    // Reset in RUN with three entries present.
    start_pulse();
    k = 0; n = 0;
    while (k < 3 && n < 20) begin
      was = Running;
      WriteValid = Running; WriteData = 32'hC0 + 32'(k); PCInstruction = pc;
      tick();
      if (was) k++;
      pc += 4; n++;
    end
    WriteValid = 1'b0;
    PCInstruction = pc;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_ignored_run", 32'(Running), 32'd1);
    check("pre_rst_entries", 32'(TraceEmpty), 32'd0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("abort_empty", 32'(TraceEmpty), 32'd1);
    check("abort_cycles", CycleCount, 32'd0);
    check("abort_idle", 32'(Running), 32'd0);
    check("abort_corerst", 32'(CoreRst), 32'd1);

    // Randomized traffic against the model.
    pc = 32'h0;
    for (int i = 0; i < 800; i++) begin
      Rst   = ($urandom_range(0, 199) == 0);
      Start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) pc = 32'($urandom_range(0, 7)) * 4;
      PCInstruction = pc;
      WriteValid = ($urandom_range(0, 1) == 1);
      WriteData  = $urandom;
      TraceRdEn  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_run_controller.md
PROC_RUN_CONTROLLER -- requirements
Module: proc_run_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PCInstruction, WriteData and TraceData.
REQ-002 SHALL have parameter RST_CYCLES, default 2, number of cycles CoreRst is held after run start (1..255).
REQ-003 SHALL have parameter MAX_CYCLES, default 1024, run-length limit in cycles before timeout.
REQ-004 SHALL have parameter HALT_REPEAT, default 4, number of consecutive cycles with an unchanged PCInstruction that signals halt (2..255).
REQ-005 SHALL have parameter TRACE_DEPTH, default 16, number of trace FIFO entries (power of two).
REQ-006 Clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Rst  input  1  reset, synchronous, active-high.
REQ-008 Start  input  1  one-cycle pulse that begins a run from IDLE.
REQ-009 PCInstruction  input  DATA_WIDTH  processor fetch word, used for halt detection.
REQ-010 WriteData  input  DATA_WIDTH  processor writeback value.
REQ-011 WriteValid  input  1  WriteData qualifier.
REQ-012 TraceRdEn  input  1  pops one trace entry.
REQ-013 CoreRst  output  1  reset driven to the processor under control.
REQ-014 Running, Done, Halted, TimedOut  output  1 each  run status.
REQ-015 CycleCount  output  32  number of RUN cycles elapsed.
REQ-016 TraceData  output  DATA_WIDTH  FIFO head; TraceEmpty, TraceFull, TraceOverflow  output  1 each.

Function
REQ-017 The FSM SHALL have the states IDLE, HOLD, RUN and DONE.
REQ-018 IDLE->HOLD on Start: CoreRst=1 and the hold counter is loaded with RST_CYCLES.
REQ-019 HOLD SHALL keep CoreRst=1 for exactly RST_CYCLES cycles, then go to RUN with CoreRst=0.
REQ-020 In RUN, Running=1 and CycleCount SHALL increment by 1 each cycle, saturating at 2^32-1.
REQ-021 Halt: if PCInstruction is equal to its previous-cycle value for HALT_REPEAT consecutive RUN cycles, the FSM SHALL go to DONE with Halted=1.
REQ-022 Timeout: when CycleCount reaches MAX_CYCLES, the FSM SHALL go to DONE with TimedOut=1.
REQ-023 If halt and timeout occur in the same cycle, both SHALL be set and Halted takes precedence for the status.
REQ-024 DONE: Done=1, Running=0, CoreRst=1; a Start in DONE SHALL clear the status and CycleCount and re-enter HOLD.
REQ-025 Start SHALL be ignored in HOLD and RUN.
REQ-026 Trace push: in RUN, WriteValid=1 and not full SHALL write WriteData; the entry is visible on TraceData the next cycle.
REQ-027 A push attempted while full SHALL drop the data and set sticky TraceOverflow, which is cleared only by Rst or Start.
REQ-028 A pop when empty SHALL be ignored; a simultaneous push and pop when full SHALL both succeed with the count unchanged.
REQ-029 The FIFO pointers SHALL wrap modulo TRACE_DEPTH, and the count SHALL be log2(TRACE_DEPTH)+1 bits wide.
REQ-030 The FIFO SHALL be readable in every state, including DONE.

Reset
REQ-031 On Rst=1 at a clock edge, the FSM SHALL go to IDLE with CoreRst=1, Running=0, Done=0, Halted=0, TimedOut=0, CycleCount=0, TraceEmpty=1, TraceFull=0, TraceOverflow=0 and TraceData=0.
REQ-032 Rst asserted mid-run SHALL abort immediately and discard the trace contents.

Structure
REQ-033 The FSM state encoding and the default parameter values SHALL live in the shared package proc_sim_pkg.
REQ-034 The trace buffer SHALL be the sub-module trace_fifo (parameters DATA_WIDTH and TRACE_DEPTH).

Verification
REQ-035 Rst, then Start with RST_CYCLES=2 -> CoreRst high for exactly 2 cycles after Start, then Running=1.
REQ-036 PCInstruction incremented by 4 each cycle, then held at 0x0000_0040 -> Halted=1 after 4 equal cycles, and CycleCount is frozen.
REQ-037 PCInstruction incremented forever with MAX_CYCLES=16 -> TimedOut=1, Done=1 and CycleCount=16.
REQ-038 20 writes of 0x1..0x14 with depth 16 -> TraceFull=1, TraceOverflow=1, and 16 pops return 0x1..0x10.
REQ-039 Rst asserted in RUN with 3 trace entries present -> IDLE, TraceEmpty=1, CycleCount=0.
REQ-040 Simultaneous push and pop when full -> the count stays 16 and the order is preserved.
